// File: rtl/xfer_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xfer_buffer_pkg
// Purpose : Shared definitions for the transfer buffer pool: writer and drain
//           state encodings and the width of the general-status reply.
// Ports   : none (package)
// Options : XFER_BUFFER_PARITY_EN (consumed by xfer_buffer_pool)
// Revision: 1.0 - initial release
// ============================================================================
package xfer_buffer_pkg;

  // Width of the free-count reply returned on gs_out.
  localparam int GS_OUT_W = 8;

  // Writer (host fill) state machine.
  typedef logic [0:0] wr_state_t;
  localparam wr_state_t W_IDLE = 1'b0;
  localparam wr_state_t W_FILL = 1'b1;

  // Drain (device stream) state machine.
  typedef logic [1:0] dr_state_t;
  localparam dr_state_t D_IDLE   = 2'd0;
  localparam dr_state_t D_FETCH  = 2'd1;
  localparam dr_state_t D_STREAM = 2'd2;

endpackage : xfer_buffer_pkg
`default_nettype wire

// File: rtl/xfer_buf_ram.sv
`default_nettype none
// ============================================================================
// Module  : xfer_buf_ram
// Purpose : Simple dual-port buffer storage. One synchronous write port and
//           one read port with a registered output. The read register only
//           updates when rd_en is high, so the last word read is held while
//           the consumer stalls.
// Ports   : clock_host         - clock
//           wr_en/wr_addr/wr_data - write port
//           rd_en/rd_addr      - read request
//           rd_data            - registered read data (valid the cycle after rd_en)
// Revision: 1.0 - initial release
// ============================================================================
module xfer_buf_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clock_host,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are deliberately never reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock_host) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock_host) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : xfer_buf_ram
`default_nettype wire

// File: rtl/xfer_buffer_pool.sv
`default_nettype none
// ============================================================================
// Module  : xfer_buffer_pool
// Purpose : Pool of NUM_BUFS transfer buffers of BUF_WORDS words each. The
//           host allocates a buffer through the general-status strobe, fills
//           it word by word, and the filled buffer is committed for the
//           device side, which streams it out with a valid/ready handshake
//           and returns the buffer to the free pool after its last word.
// Ports   : clock_host, reset (async, active high)
//           gs_select, gs_write_enable -> gs_out, gs_out_enable (status/alloc)
//           host_select, hwrite_enable, host_wdata -> wr_err (host fill side)
//           dev_valid, dev_ready, dev_data, dev_last (device drain side)
//           dev_perr (only with XFER_BUFFER_PARITY_EN)
// Options : XFER_BUFFER_PARITY_EN - store an even-parity bit per word and flag
//           words failing the check on dev_perr.
// Revision: 1.0 - initial release
// ============================================================================
module xfer_buffer_pool
  import xfer_buffer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BUF_WORDS = 1024,
  parameter int NUM_BUFS  = 4
) (
  input  logic                clock_host,
  input  logic                reset,
  input  logic                gs_select,
  input  logic                gs_write_enable,
  output logic [GS_OUT_W-1:0] gs_out,
  output logic                gs_out_enable,
  input  logic                host_select,
  input  logic                hwrite_enable,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                dev_valid,
  input  logic                dev_ready,
  output logic [DATA_W-1:0]   dev_data,
  output logic                dev_last,
`ifdef XFER_BUFFER_PARITY_EN
  output logic                dev_perr,
`endif
  output logic                wr_err
);

  localparam int WORD_W = $clog2(BUF_WORDS);
  localparam int IDX_W  = $clog2(NUM_BUFS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int ADDR_W = IDX_W + WORD_W;
`ifdef XFER_BUFFER_PARITY_EN
  localparam int RAM_W  = DATA_W + 1;
`else
  localparam int RAM_W  = DATA_W;
`endif
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BUF_WORDS - 1);

  // --------------------------------------------------------------------------
  // Free-index FIFO
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] free_mem [NUM_BUFS];
  logic [IDX_W-1:0] free_rd;
  logic [IDX_W-1:0] free_wr;
  logic [CNT_W-1:0] free_cnt;
  logic             free_push;
  logic [IDX_W-1:0] free_push_idx;

  // --------------------------------------------------------------------------
  // Commit FIFO (filled buffers, in fill order)
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] commit_mem [NUM_BUFS];
  logic [IDX_W-1:0] commit_rd;
  logic [IDX_W-1:0] commit_wr;
  logic [CNT_W-1:0] commit_cnt;
  logic             commit_push;
  logic             commit_pop;
  logic             commit_avail;

  // --------------------------------------------------------------------------
  // Writer / drain state
  // --------------------------------------------------------------------------
  wr_state_t         wr_state;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] wr_word;
  logic              alloc;
  logic              host_wr;
  logic              fill_wr;
  logic              fill_done;

  dr_state_t         dr_state;
  logic [IDX_W-1:0]  dr_idx;
  logic [WORD_W-1:0] dr_word;     // index of the word currently presented
  logic [WORD_W-1:0] dr_word_nxt;
  logic              dr_fire;
  logic              dr_at_last;

  // RAM interface
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [RAM_W-1:0]  ram_wdata;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [RAM_W-1:0]  ram_rdata;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign alloc        = gs_select && gs_write_enable && (wr_state == W_IDLE) && (free_cnt != '0);
  assign host_wr      = host_select && hwrite_enable;
  assign fill_wr      = host_wr && (wr_state == W_FILL);
  assign fill_done    = fill_wr && (wr_word == LAST_WORD);

  assign commit_avail = (commit_cnt != '0);
  assign dr_fire      = (dr_state == D_STREAM) && dev_ready;
  assign dr_at_last   = (dr_word == LAST_WORD);
  assign dr_word_nxt  = dr_word + WORD_W'(1);

  // A buffer is released on the handshake of its final word. The next
  // committed buffer is taken either from idle or straight off that final
  // handshake, so back-to-back buffers skip the idle state.
  assign free_push     = dr_fire && dr_at_last;
  assign free_push_idx = dr_idx;
  assign commit_push   = fill_done;
  assign commit_pop    = commit_avail &&
                         (((dr_state == D_IDLE)) || (dr_fire && dr_at_last));

  // --------------------------------------------------------------------------
  // Free FIFO: reset preloads every index. Push and pop may both occur in one
  // cycle; the count is then unchanged.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_host or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        free_mem[i] <= IDX_W'(i);
      end
      free_rd  <= '0;
      free_wr  <= '0;
      free_cnt <= CNT_W'(NUM_BUFS);
    end else begin
      if (free_push) begin
        free_mem[free_wr] <= free_push_idx;
        free_wr           <= free_wr + IDX_W'(1);
      end
      if (alloc) begin
        free_rd <= free_rd + IDX_W'(1);
      end
      case ({free_push, alloc})
        2'b10:   free_cnt <= free_cnt + CNT_W'(1);
        2'b01:   free_cnt <= free_cnt - CNT_W'(1);
        default: free_cnt <= free_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Commit FIFO: the entry storage needs no reset, only the pointers do.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_host) begin
    if (commit_push) begin
      commit_mem[commit_wr] <= wr_idx;
    end
  end

  always_ff @(posedge clock_host or posedge reset) begin
    if (reset) begin
      commit_rd  <= '0;
      commit_wr  <= '0;
      commit_cnt <= '0;
    end else begin
      if (commit_push) begin
        commit_wr <= commit_wr + IDX_W'(1);
      end
      if (commit_pop) begin
        commit_rd <= commit_rd + IDX_W'(1);
      end
      case ({commit_push, commit_pop})
        2'b10:   commit_cnt <= commit_cnt + CNT_W'(1);
        2'b01:   commit_cnt <= commit_cnt - CNT_W'(1);
        default: commit_cnt <= commit_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // General status: reply carries the free count as seen in the request cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_host or posedge reset) begin
    if (reset) begin
      gs_out        <= '0;
      gs_out_enable <= 1'b0;
    end else begin
      gs_out_enable <= gs_select;
      if (gs_select) begin
        gs_out <= GS_OUT_W'(free_cnt);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Writer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_host or posedge reset) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_idx   <= '0;
      wr_word  <= '0;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= host_wr && (wr_state == W_IDLE);
      case (wr_state)
        W_IDLE: begin
          if (alloc) begin
            wr_idx   <= free_mem[free_rd];
            wr_word  <= '0;
            wr_state <= W_FILL;
          end
        end
        W_FILL: begin
          if (fill_wr) begin
            // Counter wraps to zero on the final word.
            wr_word <= wr_word + WORD_W'(1);
            if (fill_done) begin
              wr_state <= W_IDLE;
            end
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_host or posedge reset) begin
    if (reset) begin
      dr_state <= D_IDLE;
      dr_idx   <= '0;
      dr_word  <= '0;
    end else begin
      case (dr_state)
        D_IDLE: begin
          if (commit_avail) begin
            dr_idx   <= commit_mem[commit_rd];
            dr_state <= D_FETCH;
          end
        end
        D_FETCH: begin
          // Word 0 read is in flight this cycle.
          dr_word  <= '0;
          dr_state <= D_STREAM;
        end
        D_STREAM: begin
          if (dr_fire) begin
            dr_word <= dr_word_nxt;
            if (dr_at_last) begin
              if (commit_avail) begin
                dr_idx   <= commit_mem[commit_rd];
                dr_state <= D_FETCH;
              end else begin
                dr_state <= D_IDLE;
              end
            end
          end
        end
        default: dr_state <= D_IDLE;
      endcase
    end
  end

  // Read port: word 0 is fetched in D_FETCH; afterwards the following word is
  // fetched on each handshake so the stream sustains one word per cycle. No
  // read is issued while stalled, which keeps the presented word stable.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = {dr_idx, {WORD_W{1'b0}}};
    if (dr_state == D_FETCH) begin
      ram_re = 1'b1;
    end else if (dr_fire && !dr_at_last) begin
      ram_re    = 1'b1;
      ram_raddr = {dr_idx, dr_word_nxt};
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  assign ram_we    = fill_wr;
  assign ram_waddr = {wr_idx, wr_word};
`ifdef XFER_BUFFER_PARITY_EN
  // Even parity: the stored word including its parity bit has an even number
  // of ones.
  assign ram_wdata = {^host_wdata, host_wdata};
`else
  assign ram_wdata = host_wdata;
`endif

  xfer_buf_ram #(
    .WIDTH  (RAM_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock_host (clock_host),
    .wr_en      (ram_we),
    .wr_addr    (ram_waddr),
    .wr_data    (ram_wdata),
    .rd_en      (ram_re),
    .rd_addr    (ram_raddr),
    .rd_data    (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Device outputs. The RAM read register is not reset, so data is gated by
  // the stream state to present zero whenever nothing is valid.
  // --------------------------------------------------------------------------
  assign dev_valid = (dr_state == D_STREAM);
  assign dev_last  = dev_valid && dr_at_last;
  assign dev_data  = dev_valid ? ram_rdata[DATA_W-1:0] : '0;
`ifdef XFER_BUFFER_PARITY_EN
  assign dev_perr  = dev_valid && (^ram_rdata);
`endif

endmodule : xfer_buffer_pool
`default_nettype wire

// File: tb/tb_xfer_buffer_pool.sv
`default_nettype none
// ============================================================================
// Module  : tb_xfer_buffer_pool
// Purpose : Self-checking bench for xfer_buffer_pool with default parameters.
//           A queue-based model predicts status replies, write errors and the
//           device word stream; directed sequences drive allocation, fill,
//           drain (continuous, stalled, toggled), pool exhaustion and reset.
// Options : XFER_BUFFER_PARITY_EN enables the parity-flip sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xfer_buffer_pool;

  localparam int DW    = 32;
  localparam int WORDS = 1024;
  localparam int NBUF  = 4;

  logic          clock_host;
  logic          reset;
  logic          gs_select;
  logic          gs_write_enable;
  logic [7:0]    gs_out;
  logic          gs_out_enable;
  logic          host_select;
  logic          hwrite_enable;
  logic [DW-1:0] host_wdata;
  logic          dev_valid;
  logic          dev_ready;
  logic [DW-1:0] dev_data;
  logic          dev_last;
  logic          wr_err;
`ifdef XFER_BUFFER_PARITY_EN
  logic          dev_perr;
`endif

  xfer_buffer_pool #(
    .DATA_W    (DW),
    .BUF_WORDS (WORDS),
    .NUM_BUFS  (NBUF)
  ) dut (
    .clock_host      (clock_host),
    .reset           (reset),
    .gs_select       (gs_select),
    .gs_write_enable (gs_write_enable),
    .gs_out          (gs_out),
    .gs_out_enable   (gs_out_enable),
    .host_select     (host_select),
    .hwrite_enable   (hwrite_enable),
    .host_wdata      (host_wdata),
    .dev_valid       (dev_valid),
    .dev_ready       (dev_ready),
    .dev_data        (dev_data),
    .dev_last        (dev_last),
`ifdef XFER_BUFFER_PARITY_EN
    .dev_perr        (dev_perr),
`endif
    .wr_err          (wr_err)
  );

  initial begin
    clock_host = 1'b0;
    forever #5 clock_host = ~clock_host;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: buffer lists as queues, expected device words as a
  // stream of beats.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int            widx;
  } beat_t;

  int            free_q[$];
  int            commit_q[$];
  beat_t         stream_q[$];
  logic [DW-1:0] fill_data[$];
  bit            filling = 0;
  int            fill_idx = 0;
  bit            exp_gs_en = 0;
  logic [7:0]    exp_gs_out = 8'h00;
  bit            exp_err = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  int            rx_count = 0;
  logic [DW-1:0] last_rx_data = '0;
  bit            last_rx_last = 0;
  int            perr_word = -1;

  initial begin
    forever begin
      @(negedge clock_host);
      if (reset) begin
        chk("rst_gs_out", gs_out, 0);
        chk("rst_gs_out_enable", gs_out_enable, 0);
        chk("rst_dev_valid", dev_valid, 0);
        chk("rst_dev_last", dev_last, 0);
        chk("rst_dev_data", dev_data, 0);
        chk("rst_wr_err", wr_err, 0);
        free_q.delete();
        for (int i = 0; i < NBUF; i++) free_q.push_back(i);
        commit_q.delete();
        stream_q.delete();
        fill_data.delete();
        filling    = 0;
        exp_gs_en  = 0;
        exp_err    = 0;
        prev_stall = 0;
      end else begin
        bit release_now;
        release_now = 0;
        // ---- compare outputs against expectations for this cycle ----
        chk("gs_out_enable", gs_out_enable, exp_gs_en);
        if (exp_gs_en) chk("gs_out", gs_out, exp_gs_out);
        chk("wr_err", wr_err, exp_err);
        if (prev_stall) begin
          chk("stall_valid", dev_valid, 1);
          chk("stall_data", dev_data, prev_data);
        end
        if (dev_valid) begin
          if (stream_q.size() == 0) begin
            chk("spurious_valid", dev_valid, 0);
          end else begin
            chk("dev_data", dev_data, stream_q[0].data);
            chk("dev_last", dev_last, stream_q[0].last);
`ifdef XFER_BUFFER_PARITY_EN
            chk("dev_perr", dev_perr, (stream_q[0].widx == perr_word));
`endif
            if (dev_ready) begin
              rx_count++;
              last_rx_data = stream_q[0].data;
              last_rx_last = stream_q[0].last;
              release_now  = stream_q[0].last;
              void'(stream_q.pop_front());
            end
          end
        end
        prev_stall = dev_valid && !dev_ready;
        prev_data  = dev_data;

        // ---- advance the model across the coming clock edge ----
        exp_gs_en = gs_select;
        if (gs_select) exp_gs_out = 8'(free_q.size());
        exp_err = host_select && hwrite_enable && !filling;
        if (filling && host_select && hwrite_enable) begin
          fill_data.push_back(host_wdata);
          if (fill_data.size() == WORDS) begin
            for (int w = 0; w < WORDS; w++) begin
              stream_q.push_back('{data: fill_data[w], last: (w == WORDS - 1), widx: w});
            end
            commit_q.push_back(fill_idx);
            fill_data.delete();
            filling = 0;
          end
        end else if (!filling && gs_select && gs_write_enable && free_q.size() > 0) begin
          fill_idx = free_q.pop_front();
          fill_data.delete();
          filling = 1;
        end
        if (release_now && commit_q.size() > 0) begin
          free_q.push_back(commit_q.pop_front());
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock_host);
    #1;
  endtask

  task automatic do_gs(input bit wr, input logic [7:0] exp, input string name);
    gs_select       = 1'b1;
    gs_write_enable = wr;
    tick();
    gs_select       = 1'b0;
    gs_write_enable = 1'b0;
    chk({name, "_en"}, gs_out_enable, 1);
    chk(name, gs_out, exp);
  endtask

  task automatic write_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      host_select   = 1'b1;
      hwrite_enable = 1'b1;
      host_wdata    = base + DW'(i);
      tick();
    end
    host_select   = 1'b0;
    hwrite_enable = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle, input string name);
    int n;
    n = 0;
    while ((stream_q.size() != 0 || dev_valid) && n < budget) begin
      if (toggle) dev_ready = ~dev_ready;
      tick();
      n++;
    end
    chk({name, "_done_in_budget"}, (n < budget), 1);
  endtask

  initial begin
    int rx0;
    int lasts;
    int n;
    reset           = 1'b1;
    gs_select       = 1'b0;
    gs_write_enable = 1'b0;
    host_select     = 1'b0;
    hwrite_enable   = 1'b0;
    host_wdata      = '0;
    dev_ready       = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Query after reset: all four buffers free.
    do_gs(1'b0, 8'h04, "query_after_reset");

    // Single buffer round trip with a ready consumer.
    dev_ready = 1'b1;
    rx0 = rx_count;
    do_gs(1'b1, 8'h04, "alloc_first");
    write_words(WORDS, 32'd0);
    wait_drain(3000, 1'b0, "drain_first");
    chk("first_word_count", rx_count - rx0, WORDS);
    chk("first_last_data", last_rx_data, 32'd1023);
    chk("first_last_flag", last_rx_last, 1);
    tick();
    do_gs(1'b0, 8'h04, "query_after_first");

    // Exhaust the pool with the consumer stalled.
    dev_ready = 1'b0;
    for (int b = 0; b < NBUF; b++) begin
      do_gs(1'b1, 8'(NBUF - b), "alloc_fill");
      write_words(WORDS, DW'(b) << 16);
    end
    do_gs(1'b1, 8'h00, "alloc_when_empty");
    for (int k = 0; k < 3; k++) begin
      host_select   = 1'b1;
      hwrite_enable = 1'b1;
      host_wdata    = 32'hDEAD0000 + DW'(k);
      tick();
      host_select   = 1'b0;
      hwrite_enable = 1'b0;
      chk("idle_write_err", wr_err, 1);
    end
    tick();
    chk("err_clears", wr_err, 0);

    // Drain; allocate on the cycle the second buffer releases so the free
    // FIFO sees a push and a pop on the same edge.
    dev_ready = 1'b1;
    lasts = 0;
    n = 0;
    while (lasts < 2 && n < 3000) begin
      tick();
      n++;
      if (dev_valid && dev_last) lasts++;
    end
    chk("second_last_seen", (lasts == 2), 1);
    do_gs(1'b1, 8'h01, "alloc_on_release");
    wait_drain(5000, 1'b0, "drain_pool");
    tick();
    do_gs(1'b0, 8'h03, "query_after_pool");

    // Allocation request while filling only reports the count.
    dev_ready = 1'b0;
    write_words(100, 32'hC0DE0000);
    do_gs(1'b1, 8'h03, "alloc_while_fill");
    write_words(WORDS - 100, 32'hC0DE0000 + 32'd100);
    wait_drain(5000, 1'b1, "drain_toggle");
    dev_ready = 1'b1;
    tick();
    do_gs(1'b0, 8'h04, "query_after_toggle");

    // Reset in the middle of a fill abandons the buffer.
    dev_ready = 1'b0;
    do_gs(1'b1, 8'h04, "alloc_partial");
    write_words(501, 32'h5A5A0000);
    reset = 1'b1;
    tick();
    chk("mid_rst_dev_valid", dev_valid, 0);
    chk("mid_rst_gs_en", gs_out_enable, 0);
    tick();
    reset = 1'b0;
    tick();
    do_gs(1'b0, 8'h04, "query_after_mid_reset");
    tick();
    chk("no_stream_after_reset", dev_valid, 0);

`ifdef XFER_BUFFER_PARITY_EN
    begin
      int idx;
      int addr;
      idx = free_q[0];
      do_gs(1'b1, 8'h04, "alloc_parity");
      write_words(WORDS, 32'h13570000);
      repeat (4) tick();
      addr = idx * WORDS + 7;
      dut.u_ram.mem[addr][DW] = ~dut.u_ram.mem[addr][DW];
      perr_word = 7;
      dev_ready = 1'b1;
      wait_drain(3000, 1'b0, "drain_parity");
      perr_word = -1;
    end
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_xfer_buffer_pool
`default_nettype wire

// File: doc/xfer_buffer_pool.md
XFER_BUFFER_POOL -- requirements
Module: xfer_buffer_pool

Interface
REQ-001 SHALL have parameter DATA_W, default 32: host and device data width in bits.
REQ-002 SHALL have parameter BUF_WORDS, default 1024: words per buffer, power of two, at least 4.
REQ-003 SHALL have parameter NUM_BUFS, default 4: buffer count, power of two, 2..128.
REQ-004 SHALL have port clock_host, input, 1: the only clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port gs_select, input, 1: general-status request strobe.
REQ-007 SHALL have port gs_write_enable, input, 1: with gs_select, 1 = allocate a receive buffer, 0 = query only.
REQ-008 SHALL have port gs_out, output, 8: free-buffer count returned for a status request.
REQ-009 SHALL have port gs_out_enable, output, 1: gs_out valid, one-cycle pulse.
REQ-010 SHALL have port host_select, input, 1: host data-phase select.
REQ-011 SHALL have port hwrite_enable, input, 1: host write strobe, qualified by host_select.
REQ-012 SHALL have port host_wdata, input, DATA_W: host write data.
REQ-013 SHALL have port dev_valid, output, 1: device-side data valid.
REQ-014 SHALL have port dev_ready, input, 1: device-side consumer ready.
REQ-015 SHALL have port dev_data, output, DATA_W: device-side drain data.
REQ-016 SHALL have port dev_last, output, 1: marks the final word of a buffer.
REQ-017 SHALL have port wr_err, output, 1: one-cycle pulse when a host write is rejected.

Function
REQ-018 Free pool: a NUM_BUFS-entry index FIFO SHALL hold free buffers; a commit FIFO SHALL hold filled buffers in fill order.
REQ-019 Status request: gs_select=1 in cycle N SHALL give gs_out_enable=1 in cycle N+1, with gs_out = free count sampled in cycle N, zero-extended to 8 bits.
REQ-020 Allocation: a request with gs_write_enable=1, writer in W_IDLE and free count >0 SHALL pop one index, set the writer to W_FILL and clear the word counter.
REQ-021 An allocation request with free count 0, or made while in W_FILL, SHALL return the count only; nothing is allocated.
REQ-022 Writer FSM SHALL have two states: W_IDLE and W_FILL.
REQ-023 In W_FILL, each cycle with host_select=1 and hwrite_enable=1 SHALL store host_wdata at the word-counter address and increment the counter.
REQ-024 The write that stores word BUF_WORDS-1 SHALL push the index to the commit FIFO and return the writer to W_IDLE on the same edge.
REQ-025 A host write in W_IDLE SHALL be discarded and SHALL pulse wr_err one cycle later.
REQ-026 Drain FSM SHALL have three states: D_IDLE, D_FETCH and D_STREAM.
REQ-027 D_IDLE to D_FETCH: when the commit FIFO is non-empty; one-cycle RAM read latency; D_FETCH to D_STREAM.
REQ-028 D_STREAM: dev_valid=1; words move only on dev_valid&dev_ready; next word is prefetched so back-to-back transfers run at 1 word/cycle.
REQ-029 dev_data and dev_valid SHALL stay stable while dev_ready=0.
REQ-030 dev_last SHALL be 1 on word BUF_WORDS-1; its transfer SHALL push the index back to the free FIFO, and the FSM then goes to D_FETCH if another buffer is committed, else D_IDLE.
REQ-031 A free-FIFO push (drain release) and pop (allocation) in the same cycle SHALL both take effect; the free count is unchanged.
REQ-032 Word counters SHALL be log2(BUF_WORDS) bits and wrap to 0 after each buffer.

Reset
REQ-033 While reset=1: gs_out=0, gs_out_enable=0, dev_valid=0, dev_last=0, dev_data=0 and wr_err=0; both FSMs are idle, the commit FIFO is empty and the free FIFO holds indices 0..NUM_BUFS-1.
REQ-034 Reset mid-fill or mid-drain SHALL abandon the partial buffer; RAM contents are not cleared.

Configuration
REQ-035 With XFER_BUFFER_PARITY_EN defined, each stored word SHALL carry an even-parity bit that is checked on drain; port dev_perr (output, 1) SHALL be 1 alongside any dev_valid word that fails the check.
REQ-036 Without XFER_BUFFER_PARITY_EN, there is no parity storage, no check and no dev_perr port.

Structure
REQ-037 Package xfer_buffer_pkg SHALL hold the writer and drain state enums and the GS_OUT_W=8 constant.
REQ-038 Storage SHALL be one sub-module, xfer_buf_ram: a simple dual-port RAM of NUM_BUFS*BUF_WORDS words, addressed {index, word}, with registered read.

Verification
REQ-039 After reset, a query (gs_select=1, gs_write_enable=0) -> gs_out_enable pulse one cycle later with gs_out=0x04.
REQ-040 Allocate, write 1024 words of value 0..1023, dev_ready=1 -> dev_data 0..1023 in order, dev_last on 1023, then a query returns gs_out=0x04.
REQ-041 dev_ready=0, four buffers filled -> a 5th allocation request returns gs_out=0x00, and subsequent host writes each pulse wr_err.
REQ-042 Toggle dev_ready every cycle during a drain -> no lost or duplicated words; dev_data stays stable while stalled.
REQ-043 Assert reset after word 500 of a fill -> outputs return to reset values, and a query returns gs_out=0x04.
REQ-044 With XFER_BUFFER_PARITY_EN defined, force a RAM parity bit flip at word 7 -> dev_perr=1 on word 7 only.
